// File: rtl/ahb_slave_mux.sv
// ahb_slave_mux
//
// Data-phase return path of the AHB interconnect. Selects HRDATA/HREADY/HRESP
// from the slave currently in its data phase and returns them to the master.
// Also hosts the default slave (two-cycle ERROR for unmapped transfers) and a
// hang watchdog that ends stalled slave transfers with a two-cycle ERROR.
//
// Ports:
//   ahb_clk_in        clock
//   ahb_rstn_in       asynchronous active-low reset
//   multi_sel_in      data-phase select: 0 idle, 1 unmapped, k+2 slave k
//   slave_hrdata_in   concatenated slave read data, slave k at [k*W +: W]
//   slave_hready_in   per-slave HREADYOUT
//   slave_hresp_in    per-slave HRESP (1 = ERROR)
//   timeout_clr_in    clears timeout_flag_out
//   hrdata_out        read data to master
//   hready_out        HREADY to master and all slaves
//   hresp_out         HRESP to master
//   multi_ready_out   copy of hready_out for the address decoder
//   timeout_flag_out  sticky watchdog event flag

module ahb_slave_mux #(
    parameter int AHB_DATA_WIDTH = 32,
    parameter int SLAVE_DEVICES  = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                                    ahb_clk_in,
    input  logic                                    ahb_rstn_in,
    input  logic [$clog2(SLAVE_DEVICES):0]          multi_sel_in,
    input  logic [SLAVE_DEVICES*AHB_DATA_WIDTH-1:0] slave_hrdata_in,
    input  logic [SLAVE_DEVICES-1:0]                slave_hready_in,
    input  logic [SLAVE_DEVICES-1:0]                slave_hresp_in,
    input  logic                                    timeout_clr_in,
    output logic [AHB_DATA_WIDTH-1:0]               hrdata_out,
    output logic                                    hready_out,
    output logic                                    hresp_out,
    output logic                                    multi_ready_out,
    output logic                                    timeout_flag_out
);

    localparam int SEL_W = $clog2(SLAVE_DEVICES) + 1;
    // A disabled watchdog still needs a legal (non-zero) counter width.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [0:0] S_PASS = 1'b0;
    localparam logic [0:0] S_ERR2 = 1'b1;

    logic [0:0]                state;
    logic [0:0]                state_nxt;
    logic [CNT_W-1:0]          wait_cnt;
    logic [CNT_W-1:0]          wait_cnt_nxt;

    logic                      sel_slave;
    logic                      sel_unmapped;
    logic                      sel_ready;
    logic                      sel_resp;
    logic [AHB_DATA_WIDTH-1:0] sel_data;
    logic                      timeout_hit;

    // Decode the select code into the selected slave's signals. Walking every
    // slave index avoids indexing past the vector for out-of-range codes,
    // which fall through as unmapped.
    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        sel_slave = 1'b0;
        sel_ready = 1'b1;
        sel_resp  = 1'b0;
        sel_data  = '0;
        for (int k = 0; k < SLAVE_DEVICES; k++) begin
            if (multi_sel_in == SEL_W'(k + 2)) begin
                sel_slave = 1'b1;
                sel_ready = slave_hready_in[k];
                sel_resp  = slave_hresp_in[k];
                sel_data  = slave_hrdata_in[k*AHB_DATA_WIDTH +: AHB_DATA_WIDTH];
            end
        end
    end

    assign sel_unmapped = (multi_sel_in != '0) && !sel_slave;

    // The slave has already used up its TIMEOUT_CYCLES wait states.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state == S_PASS) && sel_slave &&
                         !sel_ready && (wait_cnt == CNT_W'(TIMEOUT_CYCLES));

    // Output selection and next state.
    always_comb begin
        state_nxt  = S_PASS;
        hready_out = 1'b1;
        hresp_out  = 1'b0;
        hrdata_out = '0;
        if (state == S_ERR2) begin
            hready_out = 1'b1;
            hresp_out  = 1'b1;
        end else if (sel_unmapped || timeout_hit) begin
            // First ERROR cycle from the default slave or the watchdog.
            hready_out = 1'b0;
            hresp_out  = 1'b1;
            state_nxt  = S_ERR2;
        end else if (sel_slave) begin
            hready_out = sel_ready;
            hresp_out  = sel_resp;
            hrdata_out = sel_data;
        end
    end

    assign multi_ready_out = hready_out;

    // Count consecutive wait states of the selected real slave; anything else,
    // including the hit cycle itself, restarts the count.
    always_comb begin
        wait_cnt_nxt = '0;
        if ((state == S_PASS) && sel_slave && !sel_ready && !timeout_hit) begin
            wait_cnt_nxt = (wait_cnt == '1) ? wait_cnt : wait_cnt + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
        if (!ahb_rstn_in) begin
            state            <= S_PASS;
            wait_cnt         <= '0;
            timeout_flag_out <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            // A new event takes precedence over a simultaneous clear.
            if (timeout_hit) begin
                timeout_flag_out <= 1'b1;
            end else if (timeout_clr_in) begin
                timeout_flag_out <= 1'b0;
            end
        end
    end

endmodule

// File: doc/ahb_slave_mux.md
# ahb_slave_mux

Data-phase return path of the AHB interconnect: selects HRDATA/HREADY/HRESP from the slave currently in its data phase and returns them to the master. It sits directly downstream of the AHB address decoder, consuming its data-phase select code and handing `multi_ready_out` back to it to advance the address pipeline. It also contains the default slave, which answers unmapped transfers with a two-cycle ERROR, and a hang watchdog that terminates stalled slave transfers with ERROR.

## Interface
- `AHB_DATA_WIDTH`, default 32: HRDATA width.
- `SLAVE_DEVICES`, default 2: number of real slaves.
- `TIMEOUT_CYCLES`, default 16: number of consecutive wait states before the watchdog fires; 0 disables the watchdog.
- `ahb_clk_in`  in  1  clock.
- `ahb_rstn_in`  in  1  reset: asynchronous, active-low.
- `multi_sel_in`  in  $clog2(SLAVE_DEVICES)+1  data-phase select code:
  - 0 = no data phase;
  - 1 = unmapped address;
  - k+2 = slave k.
- `slave_hrdata_in`  in  SLAVE_DEVICES*AHB_DATA_WIDTH  concatenated slave read data; slave k occupies bits [k*W +: W].
- `slave_hready_in`  in  SLAVE_DEVICES  per-slave HREADYOUT.
- `slave_hresp_in`  in  SLAVE_DEVICES  per-slave HRESP (1 = ERROR).
- `timeout_clr_in`  in  1  clears `timeout_flag_out`.
- `hrdata_out`  out  AHB_DATA_WIDTH  read data to the master.
- `hready_out`  out  1  HREADY to the master and to all slaves.
- `hresp_out`  out  1  HRESP to the master.
- `multi_ready_out`  out  1  equal to `hready_out`; advances the decoder.
- `timeout_flag_out`  out  1  sticky watchdog event flag.

## Operation
- Select code handling:
  - A code with value ≥ SLAVE_DEVICES+2 is treated as unmapped (code 1).
  - The code is stable while `hready_out`=0; this is guaranteed by the decoder.
- FSM states:
  - S_PASS: normal pass-through.
  - S_ERR2: second cycle of an ERROR response.
- S_PASS outputs, by select code:
  - code 0: `hready_out`=1, `hresp_out`=0, `hrdata_out`=0.
  - code k+2 with no timeout: `hrdata_out`, `hready_out` and `hresp_out` are passed through combinationally from slave k.
  - code 1: first ERROR cycle, `hready_out`=0, `hresp_out`=1, `hrdata_out`=0; next state S_ERR2.
  - timeout hit (code k+2, `slave_hready_in[k]`=0, `wait_cnt`==TIMEOUT_CYCLES, TIMEOUT_CYCLES≠0): first ERROR cycle regardless of the slave's outputs; next state S_ERR2; `timeout_flag_out` is set on that clock edge.
- S_ERR2 outputs: `hready_out`=1, `hresp_out`=1, `hrdata_out`=0; next state is always S_PASS.
- Back-to-back unmapped transfers: the code stays 1 after S_ERR2. Returning to S_PASS starts a fresh two-cycle error; no OKAY cycle is inserted between them.
- Watchdog counter `wait_cnt`, width $clog2(TIMEOUT_CYCLES+1):
  - Increments each S_PASS cycle in which the selected real slave has HREADY=0.
  - Clears to 0 in any other cycle: slave HREADY=1, code 0 or 1, S_ERR2, or the timeout-hit cycle itself.
  - Saturates and never wraps.
- Slave ERROR responses: passed through unchanged; the default-slave FSM is not involved.
- `timeout_flag_out`:
  - Cleared when `timeout_clr_in`=1.
  - If a clear and a set fall in the same cycle, set wins.

## Timing
- Reset values: state=S_PASS, `wait_cnt`=0, `timeout_flag_out`=0. Outputs then follow the S_PASS rules; with code 0 that gives `hready_out`=1, `hresp_out`=0, `hrdata_out`=0.
- Pass-through from select code/slave inputs to the master-side outputs is zero-latency combinational; no register sits in that path.
- Unmapped access: exactly 2 cycles, (ready 0, ERR) then (ready 1, ERR).
- Timeout: the slave is allowed TIMEOUT_CYCLES wait cycles. The first ERROR cycle is the (TIMEOUT_CYCLES+1)-th cycle of the data phase; ERR2 follows. The flag is visible the cycle after the first ERROR cycle.
- Reset asserted mid-error or mid-wait: state, counter and flag clear immediately (asynchronous). After release, no residual ERROR cycle is emitted.

## Test plan
- Reset, code 0: `hready_out`=1, `hresp_out`=0, `hrdata_out`=0, `timeout_flag_out`=0.
- Code 2, slave0 returns `hrdata` 0xA5A5_0001 with `hready`=1: same cycle `hrdata_out`=0xA5A5_0001, `hready_out`=1, `hresp_out`=0. Repeat with code 3 for slave1.
- Code 1 held for 4 cycles: output (`hready_out`,`hresp_out`) sequence is (0,1),(1,1),(0,1),(1,1).
- Code 2, slave0 `hready`=0 for 20 cycles with TIMEOUT_CYCLES=16: `hready_out`=0 and `hresp_out`=0 for cycles 1–16; cycle 17 gives (0,1); cycle 18 gives (1,1); `timeout_flag_out`=1 from cycle 18 until `timeout_clr_in` is asserted.
- Code 3 with slave1 asserting HRESP ERROR (0,1) then (1,1): passed through unchanged; flag stays 0.
- Reset asserted during the cycle-10 wait of a timeout run: all state clears; after release with code 0, `hready_out`=1 and `hresp_out`=0 with no ERR cycle.
